ir_gun_emitter: RTL and testbench

Transmit side of the laser-tag IR link. On a trigger press it emits one modulated IR burst (square-wave carrier gated for a fixed number of periods) that the hit sensor decodes. It enforces a cooldown between shots and tracks a magazine with reload. It sits between the trigger/reload pushbutton synchronisers and the IR LED driver pin.

---
 rtl/ir_gun_emitter.sv | 141 ++++++++++++++
 tb/tb_ir_gun_emitter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_gun_emitter.sv
`default_nettype none
// ============================================================================
//  Module   : ir_gun_emitter
//  Purpose  : Laser-tag IR transmit side. Each trigger press emits one burst
//             of square-wave carrier, then a forced cooldown. Also tracks a
//             magazine of shots with a reload.
//  Revision : 1.0  initial release
// ============================================================================
module ir_gun_emitter #(
  parameter int CARRIER_HALF    = 4,
  parameter int BURST_PERIODS   = 8,
  parameter int COOLDOWN_CYCLES = 32,
  parameter int AMMO_MAX        = 6,
  parameter int AMMO_W          = 3
) (
  input  logic              clk,
  input  logic              CLR,
  input  logic              fire,
  input  logic              reload,
  output logic              ir_out,
  output logic              busy,
  output logic              ready,
  output logic [AMMO_W-1:0] shots_left,
  output logic              empty,
  output logic              shot_done
);

  // Counter widths; each counter needs at least one bit even when its limit is 1.
  localparam int CW = (CARRIER_HALF    > 1) ? $clog2(CARRIER_HALF)    : 1;
  localparam int PW = (BURST_PERIODS   > 1) ? $clog2(BURST_PERIODS)   : 1;
  localparam int KW = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;

  localparam logic [CW-1:0]     c_car_last  = CW'(CARRIER_HALF - 1);
  localparam logic [PW-1:0]     c_per_last  = PW'(BURST_PERIODS - 1);
  localparam logic [KW-1:0]     c_cool_last = KW'(COOLDOWN_CYCLES - 1);
  localparam logic [AMMO_W-1:0] c_ammo_full = AMMO_W'(AMMO_MAX);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_burst = 2'd1;
  localparam logic [1:0] c_st_cool  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              ir_q, ir_d;
  logic [CW-1:0]     car_q, car_d;
  logic [PW-1:0]     per_q, per_d;
  logic [KW-1:0]     cool_q, cool_d;
  logic [AMMO_W-1:0] shots_q, shots_d;
  logic              fire_prev_q;

  logic              w_fire_rise;
  logic              w_car_wrap;
  logic              w_last_cycle;

  assign w_fire_rise  = fire & ~fire_prev_q;
  assign w_car_wrap   = (car_q == c_car_last);
  // Final cycle of the burst: last carrier count of the last low half-period.
  assign w_last_cycle = (state_q == c_st_burst) && !ir_q && w_car_wrap &&
                        (per_q == c_per_last);

  // Next-state logic for the shot sequencer, carrier generator and magazine.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    car_d   = car_q;
    per_d   = per_q;
    cool_d  = cool_q;
    shots_d = shots_q;
    case (state_q)
      c_st_idle: begin
        // Reload wins over a simultaneous trigger edge.
        if (reload) begin
          shots_d = c_ammo_full;
        end else if (w_fire_rise && (shots_q != '0)) begin
          state_d = c_st_burst;
          shots_d = shots_q - 1'b1;
          ir_d    = 1'b1;
          car_d   = '0;
          per_d   = '0;
        end
      end
      c_st_burst: begin
        if (w_car_wrap) begin
          car_d = '0;
          if (ir_q) begin
            ir_d = 1'b0;
          end else if (per_q == c_per_last) begin
            state_d = c_st_cool;
            ir_d    = 1'b0;
            cool_d  = '0;
          end else begin
            per_d = per_q + 1'b1;
            ir_d  = 1'b1;
          end
        end else begin
          car_d = car_q + 1'b1;
        end
      end
      c_st_cool: begin
        if (cool_q == c_cool_last) begin
          state_d = c_st_idle;
        end else begin
          cool_d = cool_q + 1'b1;
        end
      end
      default: begin
        state_d = c_st_idle;
        ir_d    = 1'b0;
      end
    endcase
  end

  // State registers; CLR overrides everything, including an active burst.
  always_ff @(posedge clk) begin
    if (CLR) begin
      state_q     <= c_st_idle;
      ir_q        <= 1'b0;
      car_q       <= '0;
      per_q       <= '0;
      cool_q      <= '0;
      shots_q     <= c_ammo_full;
      fire_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      car_q       <= car_d;
      per_q       <= per_d;
      cool_q      <= cool_d;
      shots_q     <= shots_d;
      fire_prev_q <= fire;
    end
  end

  assign ir_out     = ir_q;
  assign busy       = (state_q != c_st_idle);
  assign ready      = (state_q == c_st_idle) && (shots_q != '0);
  assign empty      = (shots_q == '0);
  assign shots_left = shots_q;
  assign shot_done  = w_last_cycle;

endmodule
`default_nettype wire

// File: tb/tb_ir_gun_emitter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ir_gun_emitter
//  Purpose  : Self-checking bench for ir_gun_emitter: vector table, directed
//             multi-cycle sequences and random stimulus against a timing model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ir_gun_emitter;

  localparam int H = 4;
  localparam int P = 8;
  localparam int C = 32;
  localparam int A = 6;
  localparam int W = 3;
  localparam int BURST_LEN = 2 * H * P;
  localparam int TOTAL     = BURST_LEN + C;

  logic         clk = 1'b0;
  logic         CLR = 1'b1;
  logic         fire = 1'b0;
  logic         reload = 1'b0;
  logic         ir_out, busy, ready, empty, shot_done;
  logic [W-1:0] shots_left;

  ir_gun_emitter #(
    .CARRIER_HALF(H), .BURST_PERIODS(P), .COOLDOWN_CYCLES(C),
    .AMMO_MAX(A), .AMMO_W(W)
  ) dut (
    .clk(clk), .CLR(CLR), .fire(fire), .reload(reload),
    .ir_out(ir_out), .busy(busy), .ready(ready), .shots_left(shots_left),
    .empty(empty), .shot_done(shot_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: shot count plus cycles elapsed since the current shot started
  // (0 = idle). All outputs follow from these by arithmetic on the timeline.
  int m_shots = A;
  int m_n = 0;
  bit m_prev = 1'b0;

  int cyc = 0;
  int ir_cnt, busy_cnt, done_cnt, done_at;

  typedef struct {
    logic         f, r, c;
    logic [W+4:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic f, r, c, ir, bz, rd,
                              input logic [W-1:0] sh, input logic em, dn);
    vec_t v;
    v.f = f; v.r = r; v.c = c;
    v.exp = {ir, bz, rd, sh, em, dn};
    return v;
  endfunction

  function void model_step(input logic f, r, c);
    if (c) begin
      m_shots = A; m_n = 0; m_prev = 1'b0;
    end else begin
      if (m_n != 0) begin
        m_n = m_n + 1;
        if (m_n > TOTAL) m_n = 0;
      end else if (r) begin
        m_shots = A;
      end else if (f && !m_prev && m_shots > 0) begin
        m_shots = m_shots - 1;
        m_n = 1;
      end
      m_prev = f;
    end
  endfunction

  function automatic logic [W+4:0] model_vec();
    logic ir, bz, rd, em, dn;
    logic [W-1:0] sh;
    ir = (m_n >= 1) && (m_n <= BURST_LEN) && ((((m_n - 1) / H) % 2) == 0);
    bz = (m_n != 0);
    rd = (m_n == 0) && (m_shots != 0);
    sh = W'(m_shots);
    em = (m_shots == 0);
    dn = (m_n == BURST_LEN);
    return {ir, bz, rd, sh, em, dn};
  endfunction

  function automatic logic [W+4:0] dut_vec();
    return {ir_out, busy, ready, shots_left, empty, shot_done};
  endfunction

  task automatic check_vec(input string name, input logic [W+4:0] act, exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got {ir,busy,ready,shots,empty,done}=%b expected %b",
               name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    ir_cnt = 0; busy_cnt = 0; done_cnt = 0; done_at = -1;
  endtask

  // One clock: drive inputs, take the edge, advance the model, sample at +1.
  task automatic cycle(input logic f, r, c, input bit use_model);
    fire = f; reload = r; CLR = c;
    @(posedge clk);
    model_step(f, r, c);
    #1;
    cyc++;
    if (ir_out === 1'b1) ir_cnt++;
    if (busy === 1'b1) busy_cnt++;
    if (shot_done === 1'b1) begin done_cnt++; done_at = cyc; end
    if (use_model) check_vec("model", dut_vec(), model_vec());
  endtask

  vec_t tbl[18];

  initial begin
    int s;
    logic fr;

    // ---- vector table: reset, first shot timing, ignored requests, collision
    tbl[0]  = mk(0,0,1, 0,0,1, 3'd6, 0,0);
    tbl[1]  = mk(0,0,0, 0,0,1, 3'd6, 0,0);
    tbl[2]  = mk(1,0,0, 1,1,0, 3'd5, 0,0);
    tbl[3]  = mk(1,0,0, 1,1,0, 3'd5, 0,0);
    tbl[4]  = mk(1,0,0, 1,1,0, 3'd5, 0,0);
    tbl[5]  = mk(0,0,0, 1,1,0, 3'd5, 0,0);
    tbl[6]  = mk(0,0,0, 0,1,0, 3'd5, 0,0);
    tbl[7]  = mk(1,0,0, 0,1,0, 3'd5, 0,0);
    tbl[8]  = mk(0,1,0, 0,1,0, 3'd5, 0,0);
    tbl[9]  = mk(0,0,0, 0,1,0, 3'd5, 0,0);
    tbl[10] = mk(0,0,0, 1,1,0, 3'd5, 0,0);
    tbl[11] = mk(0,0,1, 0,0,1, 3'd6, 0,0);
    tbl[12] = mk(0,1,0, 0,0,1, 3'd6, 0,0);
    tbl[13] = mk(1,1,0, 0,0,1, 3'd6, 0,0);
    tbl[14] = mk(1,0,0, 0,0,1, 3'd6, 0,0);
    tbl[15] = mk(0,0,0, 0,0,1, 3'd6, 0,0);
    tbl[16] = mk(1,0,0, 1,1,0, 3'd5, 0,0);
    tbl[17] = mk(0,0,1, 0,0,1, 3'd6, 0,0);

    for (int i = 0; i < 18; i++) begin
      cycle(tbl[i].f, tbl[i].r, tbl[i].c, 1'b0);
      check_vec($sformatf("vec%0d", i), dut_vec(), tbl[i].exp);
    end

    // ---- single shot: waveform shape, done position, busy length
    clear_counts();
    cycle(1,0,0,1); s = cyc;
    cycle(1,0,0,1); cycle(1,0,0,1);
    repeat (117) cycle(0,0,0,1);
    check_int("single_ir_high_cycles", ir_cnt, BURST_LEN / 2);
    check_int("single_done_count", done_cnt, 1);
    check_int("single_done_offset", done_at - s, BURST_LEN - 1);
    check_int("single_busy_cycles", busy_cnt, TOTAL);
    check_int("single_shots", int'(shots_left), 5);

    // ---- held trigger: exactly one burst across cooldown exit
    clear_counts();
    repeat (200) cycle(1,0,0,1);
    repeat (5) cycle(0,0,0,1);
    check_int("held_done_count", done_cnt, 1);
    check_int("held_busy_cycles", busy_cnt, TOTAL);
    check_int("held_shots", int'(shots_left), 4);

    // ---- edges in burst (cycle 10) and cooldown (cycle 69) are dropped
    clear_counts();
    for (int i = 1; i <= 100; i++) cycle(logic'(i == 1 || i == 10 || i == 69), 0, 0, 1);
    check_int("ignored_done_count", done_cnt, 1);
    check_int("ignored_shots", int'(shots_left), 3);
    cycle(1,0,0,1);
    check_int("next_edge_fires", int'(ir_out), 1);
    repeat (100) cycle(0,0,0,1);

    // ---- drain magazine, shot on empty ignored, reload restores
    for (int k = 0; k < 2; k++) begin
      cycle(1,0,0,1);
      repeat (100) cycle(0,0,0,1);
    end
    check_int("drained_shots", int'(shots_left), 0);
    check_int("drained_empty", int'(empty), 1);
    check_int("drained_ready", int'(ready), 0);
    clear_counts();
    cycle(1,0,0,1);
    repeat (20) cycle(0,0,0,1);
    check_int("empty_fire_ir", ir_cnt, 0);
    check_int("empty_fire_busy", busy_cnt, 0);
    cycle(0,1,0,1);
    check_int("reload_shots", int'(shots_left), A);
    check_int("reload_empty", int'(empty), 0);

    // ---- reload/fire collision at 3 shots, reload during burst ignored
    for (int k = 0; k < 3; k++) begin
      cycle(1,0,0,1);
      repeat (100) cycle(0,0,0,1);
    end
    check_int("pre_collision_shots", int'(shots_left), 3);
    cycle(1,1,0,1);
    check_int("collision_shots", int'(shots_left), A);
    check_int("collision_busy", int'(busy), 0);
    cycle(0,0,0,1);
    cycle(1,0,0,1);
    repeat (4) cycle(0,0,0,1);
    cycle(0,1,0,1);
    check_int("burst_reload_shots", int'(shots_left), 5);
    repeat (100) cycle(0,0,0,1);

    // ---- reset in the middle of a burst
    clear_counts();
    cycle(1,0,0,1);
    repeat (18) cycle(0,0,0,1);
    cycle(0,0,1,1);
    check_int("midreset_ir", int'(ir_out), 0);
    check_int("midreset_busy", int'(busy), 0);
    check_int("midreset_shots", int'(shots_left), A);
    check_int("midreset_no_done", done_cnt, 0);

    // ---- random stimulus against the model
    fr = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) < 3) fr = ~fr;
      cycle(fr, logic'($urandom_range(0, 99) == 0), logic'($urandom_range(0, 999) == 0), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
